// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shared 16-bit SRAM port arbiter for instruction fetch and MEM-stage load/store
//
// Purpose: grants the single asynchronous SRAM port to either the fetch (IF)
// requester or the MEM-stage load/store requester, sequences ce_n/oe_n/we_n
// through a multi-cycle FSM, drives the bidirectional data bus during writes,
// and produces per-requester stall signals and one-cycle ready pulses.
//
// Optional feature: define SRAM_ARB_ROUND_ROBIN_EN to alternate the grant when
// both requesters are pending in IDLE (1-bit last-grant register). Without it,
// MEM always wins over IF and no last-grant register exists.
//
// Ports:
//   clk        in    system clock, rising edge
//   rst        in    asynchronous active-low reset
//   if_req     in    fetch request (level, held until if_ready)
//   if_addr    in    fetch word address
//   if_data    out   fetched word, valid while if_ready=1
//   if_ready   out   one-cycle fetch completion pulse
//   mem_read   in    load request (level)
//   mem_write  in    store request (level); wins over mem_read when both set
//   mem_addr   in    load/store word address
//   mem_wdata  in    store data
//   mem_rdata  out   load data, valid while mem_ready=1
//   mem_ready  out   one-cycle load/store completion pulse
//   stall_if   out   if_req & ~if_ready
//   stall_mem  out   (mem_read|mem_write) & ~mem_ready
//   ram_addr   out   SRAM address {HIGH_BITS, 16-bit word address}
//   ram_data   inout SRAM data bus, high-Z unless writing
//   ram_ce_n   out   SRAM chip enable, active-low
//   ram_oe_n   out   SRAM output enable, active-low
//   ram_we_n   out   SRAM write enable, active-low

module sram_arbiter #(
    parameter int                 WAIT_CYCLES = 1,
    parameter int                 RAM_AW      = 18,
    parameter logic [RAM_AW-17:0] HIGH_BITS   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [15:0]       if_addr,
    output logic [15:0]       if_data,
    output logic              if_ready,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [15:0]       mem_addr,
    input  logic [15:0]       mem_wdata,
    output logic [15:0]       mem_rdata,
    output logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic [RAM_AW-1:0] ram_addr,
    inout  wire  [15:0]       ram_data,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    // Counter must be at least one bit wide even when WAIT_CYCLES is 0.
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_STROBE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic              cnt_last;
    logic              mem_pend;
    logic              any_req;
    logic              grant_mem;
    logic              gnt_mem_q;
    logic              is_write_q;
    logic [15:0]       wdata_q;
    logic [15:0]       if_data_q;
    logic [15:0]       mem_rdata_q;
    logic [RAM_AW-1:0] addr_q;
    logic              bus_drive;

    assign mem_pend = mem_read | mem_write;
    assign any_req  = mem_pend | if_req;
    assign cnt_last = (cnt == CW'(WAIT_CYCLES));

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // High when the most recent grant went to MEM; under contention the
    // other requester is preferred.
    logic last_mem_q;

    assign grant_mem = mem_pend & (~if_req | ~last_mem_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_mem_q <= 1'b0;
        end else if (state == S_IDLE && any_req) begin
            last_mem_q <= grant_mem;
        end
    end
`else
    // Fixed priority: the MEM stage holds the older instruction.
    assign grant_mem = mem_pend;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt = (grant_mem && mem_write) ? S_WR_SETUP : S_RD;
                end
            end
            S_RD:        if (cnt_last) state_nxt = S_DONE;
            S_WR_SETUP:  state_nxt = S_WR_STROBE;
            S_WR_STROBE: if (cnt_last) state_nxt = S_DONE;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Output decode (Moore: a function of the registered state only)
    always_comb begin
        ram_ce_n  = 1'b1;
        ram_oe_n  = 1'b1;
        ram_we_n  = 1'b1;
        bus_drive = 1'b0;
        case (state)
            S_RD: begin
                ram_ce_n = 1'b0;
                ram_oe_n = 1'b0;
            end
            S_WR_SETUP: begin
                ram_ce_n  = 1'b0;
                bus_drive = 1'b1;
            end
            S_WR_STROBE: begin
                ram_ce_n  = 1'b0;
                ram_we_n  = 1'b0;
                bus_drive = 1'b1;
            end
            S_DONE: begin
                // Keep the chip selected and the data driven past the
                // rising we_n edge so the SRAM sees its data hold time.
                ram_ce_n  = ~is_write_q;
                bus_drive = is_write_q;
            end
            default: begin
                ram_ce_n = 1'b1;
            end
        endcase
    end

    // Strobe-width counter; restarts whenever the FSM is not in a timed state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if ((state == S_RD || state == S_WR_STROBE) && !cnt_last) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Grant, address and write data are latched once, at the IDLE edge,
    // so the access is immune to requests changing or dropping mid-flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_mem_q   <= 1'b0;
            is_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 16'h0000;
            if_data_q   <= 16'h0000;
            mem_rdata_q <= 16'h0000;
        end else begin
            if (state == S_IDLE && any_req) begin
                gnt_mem_q  <= grant_mem;
                is_write_q <= grant_mem & mem_write;
                addr_q     <= {HIGH_BITS, (grant_mem ? mem_addr : if_addr)};
                wdata_q    <= mem_wdata;
            end
            if (state == S_RD && cnt_last) begin
                if (gnt_mem_q) begin
                    mem_rdata_q <= ram_data;
                end else begin
                    if_data_q <= ram_data;
                end
            end
        end
    end

    assign ram_data  = bus_drive ? wdata_q : {16{1'bz}};
    assign ram_addr  = addr_q;
    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ready  = (state == S_DONE) & ~gnt_mem_q;
    assign mem_ready = (state == S_DONE) &  gnt_mem_q;
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = mem_pend & ~mem_ready;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter

module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_data;
    logic        if_ready;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
    logic [17:0] ram_addr;
    wire  [15:0] ram_data;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    bit first_mem;

    logic [15:0] sram [0:65535];

    sram_arbiter #(.WAIT_CYCLES(1), .RAM_AW(18), .HIGH_BITS(2'b00)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ready(if_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM model: drives the bus while selected and output-enabled.
    assign ram_data = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr[15:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!rst) begin
            sram[16'h0004] <= 16'h4901;
            sram[16'h0010] <= 16'h1234;
        end else if (!ram_ce_n && !ram_we_n) begin
            sram[ram_addr[15:0]] <= ram_data;
        end
    end

    // Bus-safety watch: never oe_n and we_n low together, never drive while oe_n=0.
    always @(negedge clk) begin
        if (rst) begin
            if (!ram_oe_n && !ram_we_n) viol++;
            if (dut.bus_drive && !ram_oe_n) viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        if_req = 0; if_addr = 0; mem_read = 0; mem_write = 0; mem_addr = 0; mem_wdata = 0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        first_mem = 1'b0;
`else
        first_mem = 1'b1;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ce_n", ram_ce_n, 1);
        chk("rst_oe_n", ram_oe_n, 1);
        chk("rst_we_n", ram_we_n, 1);
        chk("rst_drive", dut.bus_drive, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_if_data", if_data, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;

        // Fetch from word 4
        if_req = 1; if_addr = 16'h0004;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("fetch_oe_c%0d", c), ram_oe_n, !(c == 1 || c == 2));
            chk($sformatf("fetch_stall_c%0d", c), stall_if, c < 3);
            chk($sformatf("fetch_ready_c%0d", c), if_ready, c == 3);
            if (c == 1) chk("fetch_addr", ram_addr, 18'h00004);
            if (c == 3) chk("fetch_data", if_data, 16'h4901);
        end
        @(posedge clk) #1 if_req = 0;

        // Store BEEF to 0x8000
        mem_write = 1; mem_addr = 16'h8000; mem_wdata = 16'hBEEF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("st_we_c%0d", c), ram_we_n, !(c == 2 || c == 3));
            chk($sformatf("st_oe_c%0d", c), ram_oe_n, 1);
            chk($sformatf("st_drive_c%0d", c), dut.bus_drive, c >= 1);
            chk($sformatf("st_ready_c%0d", c), mem_ready, c == 4);
            chk($sformatf("st_stall_c%0d", c), stall_mem, c < 4);
        end
        @(posedge clk) #1 mem_write = 0;
        @(negedge clk);
        chk("st_drive_after", dut.bus_drive, 0);
        chk("st_ce_after", ram_ce_n, 1);
        chk("st_ram_content", sram[16'h8000], 16'hBEEF);

        // Load back from 0x8000
        @(posedge clk) #1;
        mem_read = 1; mem_addr = 16'h8000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("ld_ready_c%0d", c), mem_ready, c == 3);
            if (c == 3) chk("ld_data", mem_rdata, 16'hBEEF);
        end
        @(posedge clk) #1 mem_read = 0;

        // Contention: fetch of word 4 and load of word 0x10 together
        if_req = 1; if_addr = 16'h0004; mem_read = 1; mem_addr = 16'h0010;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("ct_oe_c%0d", c), ram_oe_n, !(c == 1 || c == 2 || c == 5 || c == 6));
            chk($sformatf("ct_mem_ready_c%0d", c), mem_ready, c == (first_mem ? 3 : 7));
            chk($sformatf("ct_if_ready_c%0d", c), if_ready, c == (first_mem ? 7 : 3));
            if (c == 1) chk("ct_addr_first", ram_addr, first_mem ? 18'h00010 : 18'h00004);
            if (c == 5) chk("ct_addr_second", ram_addr, first_mem ? 18'h00004 : 18'h00010);
            if (c == 3 || c == 7) begin
                if ((c == 3) == first_mem) chk("ct_mem_data", mem_rdata, 16'h1234);
                else                       chk("ct_if_data", if_data, 16'h4901);
                @(posedge clk) #1;
                if ((c == 3) == first_mem) mem_read = 0;
                else                       if_req = 0;
            end
        end

        // Reset asserted in cycle 2 of a store
        mem_write = 1; mem_addr = 16'h0020; mem_wdata = 16'h5555;
        for (int c = 0; c < 3; c++) @(negedge clk);
        chk("rs_we_before", ram_we_n, 0);
        #1 rst = 1'b0;
        #1;
        chk("rs_we_n", ram_we_n, 1);
        chk("rs_ce_n", ram_ce_n, 1);
        chk("rs_drive", dut.bus_drive, 0);
        chk("rs_mem_ready", mem_ready, 0);
        chk("rs_ram_addr", ram_addr, 0);
        chk("rs_mem_rdata", mem_rdata, 0);
        chk("rs_if_data", if_data, 0);
        mem_write = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rs_hold_ready", mem_ready, 0);
        end
        rst = 1'b1;
        @(negedge clk) chk("rs_post_ready", mem_ready, 0);
        @(posedge clk) #1;
        if_req = 1; if_addr = 16'h0004;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rs_fetch_ready_c%0d", c), if_ready, c == 3);
            if (c == 3) chk("rs_fetch_data", if_data, 16'h4901);
        end
        @(posedge clk) #1 if_req = 0;

        // Read and write asserted together: a write must happen
        mem_read = 1; mem_write = 1; mem_addr = 16'h0030; mem_wdata = 16'hA5A5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("rw_oe_c%0d", c), ram_oe_n, 1);
            chk($sformatf("rw_we_c%0d", c), ram_we_n, !(c == 2 || c == 3));
            chk($sformatf("rw_ready_c%0d", c), mem_ready, c == 4);
        end
        @(posedge clk) #1;
        mem_read = 0; mem_write = 0;
        @(negedge clk);
        chk("rw_ram_content", sram[16'h0030], 16'hA5A5);
        chk("bus_safety", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
